alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares one 16-bit ALU (ops: ADD with carry-out, pass-B identity) between NUM_REQ requesters, e.g. core execute stage, address/PC incrementer, debug port.
- Round-robin grant; operands and result are registered, so the ALU sees stable inputs for one full cycle.
- Sits between the requesters and the ALU instance; the ALU stays combinational and untouched.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..8.
- W, 16, operand/result width; must match the ALU.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request strobe
- req_ready  out  NUM_REQ  one-hot grant; request accepted when valid&ready
- req_a  in  NUM_REQ*W  operand A, requester i at bits [i*W +: W]
- req_b  in  NUM_REQ*W  operand B, same packing
- req_op  in  NUM_REQ  op per requester: 0=ADD, 1=pass B
- alu_a  out  W  to ALU A
- alu_b  out  W  to ALU B
- alu_op  out  1  to ALU OP
- alu_c  in  W  ALU result
- alu_cout  in  1  ALU carry-out
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed when rsp_valid&rsp_ready
- rsp_id  out  3  index of requester owning the result
- rsp_c  out  W  registered result
- rsp_cout  out  1  registered carry-out; 0 for pass-B
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, reset_n=0): state=IDLE, rr_ptr=0, operand regs=0, alu_op=0, rsp_valid=0, rsp_id=0, rsp_c=0, rsp_cout=0, busy=0. req_ready=0 while in reset.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Winner = first i with req_valid[i], scanning i = rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready is combinational from req_valid and rr_ptr: one-hot on the winner, all zero if no request, asserted only in IDLE.
  - On a grant edge: latch req_a/req_b/req_op of the winner into the operand regs, grant_id=winner, rr_ptr=(winner+1) mod NUM_REQ, go to EXEC.
- EXEC:
  - alu_a/alu_b/alu_op are always driven from the operand regs, never combinationally from req_*.
  - At the end of EXEC: rsp_c<=alu_c, rsp_cout<=alu_cout, rsp_id<=grant_id, rsp_valid<=1, go to RESP.
- RESP:
  - rsp_valid, rsp_id, rsp_c and rsp_cout are held stable until rsp_ready.
  - On rsp_valid&rsp_ready: rsp_valid<=0, go to IDLE. rsp_c/rsp_cout/rsp_id keep their last values.
  - No new grant is issued in RESP (single outstanding op).
- Timing:
  - Latency: grant in cycle t, rsp_valid high from cycle t+2.
  - Peak throughput: one op per 3 cycles with rsp_ready tied high.
- Arithmetic:
  - ADD: {cout,c} = A+B, 17-bit result, wraps modulo 2^16.
  - Pass-B: c=B, cout=0. The ALU supplies these values; the arbiter only registers them.
- Boundaries:
  - All requesters valid: strict rotation, no starvation; each requester waits at most NUM_REQ-1 grants.
  - Requester drops req_valid before a grant: no effect, no grant.
  - req_valid while busy: req_ready=0; the request must be held.
  - rsp_ready high outside RESP: ignored.
  - reset_n asserted mid-EXEC or mid-RESP: the op is discarded, all state returns to reset values immediately, and no rsp_valid pulse follows reset release.
  - rr_ptr is always < NUM_REQ; out-of-range values cannot be reached.

Test Plan:
- Req0 alone, ADD, A=0xFFFF, B=0x0001 -> req_ready[0] for 1 cycle; rsp_valid 2 cycles later; rsp_c=0x0000, rsp_cout=1, rsp_id=0.
- Req1 alone, pass-B, A=0x1234, B=0xBEEF -> rsp_c=0xBEEF, rsp_cout=0, rsp_id=1.
- Req0 and Req1 valid continuously, rsp_ready=1, reset rr_ptr=0 -> grant order 0,1,0,1; req0 ADD 0x0003+0x0004 gives 0x0007; req1 ADD 0x8000+0x8000 gives 0x0000 with cout=1; one grant every 3 cycles.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid, with req1 pending -> rsp_c/rsp_id stable, req_ready=0 throughout; req1 granted the cycle after the rsp handshake.
- reset_n low for 1 cycle during EXEC -> rsp_valid never asserts for that op; all outputs 0; next grant goes to the lowest valid index.
- NUM_REQ=4, all valid, rr_ptr advanced to 3 -> grant order 3,0,1,2.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between NUM_REQ requesters.
// Operands and results are registered, so at most one operation is in flight.
//
//   state | meaning
//   IDLE  | scan requesters from rr_ptr and grant the first valid one
//   EXEC  | registered operands drive the ALU; its result is captured at the end of the cycle
//   RESP  | result held on rsp_* until rsp_ready
module alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int W       = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*W-1:0] req_a,
  input  logic [NUM_REQ*W-1:0] req_b,
  input  logic [NUM_REQ-1:0]   req_op,
  output logic [W-1:0]         alu_a,
  output logic [W-1:0]         alu_b,
  output logic                 alu_op,
  input  logic [W-1:0]         alu_c,
  input  logic                 alu_cout,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2:0]           rsp_id,
  output logic [W-1:0]         rsp_c,
  output logic                 rsp_cout,
  output logic                 busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] scan_idx;
  logic [PW:0]   scan_sum;
  logic          win_found;
  logic          grant;
  logic [2:0]    grant_id;

  // Scan from rr_ptr with wrap-around; the sum is one bit wider so the wrap works for any NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (PW+1)'(k);
      if (scan_sum >= (PW+1)'(NUM_REQ)) begin
        scan_sum = scan_sum - (PW+1)'(NUM_REQ);
      end
      scan_idx = scan_sum[PW-1:0];
      if (!win_found && req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  assign grant = (state == IDLE) && win_found;
  assign busy  = (state != IDLE);

  always_comb begin
    req_ready = '0;
    if (grant && reset_n) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_found) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr    <= '0;
      grant_id  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_c     <= '0;
      rsp_cout  <= 1'b0;
    end else begin
      if (grant) begin
        alu_a    <= req_a[win_idx*W +: W];
        alu_b    <= req_b[win_idx*W +: W];
        alu_op   <= req_op[win_idx];
        grant_id <= 3'(win_idx);
        rr_ptr   <= (win_idx == PW'(NUM_REQ-1)) ? '0 : win_idx + PW'(1);
      end
      if (state == EXEC) begin
        rsp_c     <= alu_c;
        rsp_cout  <= alu_cout;
        rsp_id    <= grant_id;
        rsp_valid <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
